// File: rtl/sa_seq_ctrl.sv
// sa_seq_ctrl: weight-load, skewed activation streaming and output-write sequencer for a systolic array
module sa_seq_ctrl #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int KW   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [KW-1:0]           cfg_k,
    output logic                    busy,
    output logic                    done,
    output logic                    w_rd_en,
    output logic [$clog2(ROWS)-1:0] w_rd_addr,
    output logic                    a_rd_en,
    output logic [KW-1:0]           a_rd_addr,
    output logic [ROWS-1:0]         a_lane_vld,
    output logic                    psum_clr,
    output logic [COLS-1:0]         o_col_vld,
    output logic                    o_wr_en,
    output logic [KW-1:0]           o_wr_addr
);
    localparam int AW = $clog2(ROWS);
    localparam int SW = $clog2((1 << KW) + ROWS + COLS);
    typedef enum logic [2:0] {IDLE, LOAD_W, SETTLE, STREAM, DONE} state_t;
    state_t state, next;
    logic [SW-1:0] cnt, kx;
    logic [KW-1:0] k_reg;
    logic strm;
    assign kx = SW'(k_reg);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            k_reg <= '0;
        end else begin
            state <= next;
            cnt   <= (state != next || state == IDLE) ? '0 : cnt + SW'(1);
            if (state == IDLE && start) k_reg <= cfg_k;
        end
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? (cfg_k == '0 ? DONE : LOAD_W) : IDLE;
            LOAD_W:  next = cnt == SW'(ROWS - 1) ? SETTLE : LOAD_W;
            SETTLE:  next = cnt == SW'(1) ? STREAM : SETTLE;
            STREAM:  next = cnt == kx + SW'(ROWS + COLS - 1) ? DONE : STREAM;
            default: next = IDLE;
        endcase
        strm       = state == STREAM;
        busy       = state != IDLE;
        done       = state == DONE;
        psum_clr   = busy;
        w_rd_en    = state == LOAD_W;
        w_rd_addr  = w_rd_en ? AW'(cnt) : '0;
        a_rd_en    = strm && cnt < kx;
        a_rd_addr  = a_rd_en ? KW'(cnt) : '0;
        o_wr_en    = strm && cnt >= SW'(ROWS + COLS) && cnt < kx + SW'(ROWS + COLS);
        o_wr_addr  = o_wr_en ? KW'(cnt - SW'(ROWS + COLS)) : '0;
        a_lane_vld = '0;
        o_col_vld  = '0;
        for (int i = 0; i < ROWS; i++)
            a_lane_vld[i] = strm && cnt >= SW'(i + 1) && cnt <= SW'(i) + kx;
        for (int i = 0; i < COLS; i++)
            o_col_vld[i] = strm && cnt >= SW'(ROWS + 1 + i) && cnt <= SW'(ROWS + i) + kx;
    end
endmodule
